// File: rtl/arb_pkg.sv
// Shared state encodings, default widths and the round-robin pick used by arbiter_2ne1.
package arb_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SERVE0 = 2'd1,
      SERVE1 = 2'd2
   } arb_state_t;

   // On contention the requester that was not served most recently wins.
   function automatic arb_state_t arbitrate(input logic r0, input logic r1, input logic last);
      arb_state_t pick;
      pick = IDLE;
      if (r0 && r1)
         pick = last ? SERVE0 : SERVE1;
      else if (r0)
         pick = SERVE0;
      else if (r1)
         pick = SERVE1;
      return pick;
   endfunction

endpackage

// File: rtl/mux2ne1_w.sv
// WIDTH-wide 2-to-1 multiplexer; sel=0 passes d0, sel=1 passes d1.
module mux2ne1_w #(
   parameter int WIDTH = 8
) (
   input  logic             sel,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   output logic [WIDTH-1:0] y
);

   assign y = sel ? d1 : d0;

endmodule

// File: rtl/arbiter_2ne1.sv
// Two-requester round-robin arbiter with registered grants and a transfer counter.
// Optional macro ARB_LOCK_EN adds lock0/lock1 to keep a grant across transfers.
module arbiter_2ne1
   import arb_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
`ifdef ARB_LOCK_EN
   input  logic             lock0,
   input  logic             lock1,
`endif
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             sel,
   output logic             gnt0,
   output logic             gnt1,
   output logic [CNT_W-1:0] xfer_cnt
);

   arb_state_t state;
   arb_state_t next_state;
   logic       last_served;
   logic       xfer;
   logic       lock_hold;

   assign xfer = out_valid & out_ready;

`ifdef ARB_LOCK_EN
   assign lock_hold = ((state == SERVE0) & lock0 & req0) | ((state == SERVE1) & lock1 & req1);
`else
   assign lock_hold = 1'b0;
`endif

   // After a transfer the just-served requester counts as last_served for the re-pick.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:
            next_state = arbitrate(req0, req1, last_served);
         SERVE0: begin
            if (xfer)
               next_state = lock_hold ? SERVE0 : arbitrate(req0, req1, 1'b0);
            else if (!req0)
               next_state = arbitrate(req0, req1, last_served);
         end
         SERVE1: begin
            if (xfer)
               next_state = lock_hold ? SERVE1 : arbitrate(req0, req1, 1'b1);
            else if (!req1)
               next_state = arbitrate(req0, req1, last_served);
         end
         default:
            next_state = IDLE;
      endcase
   end

   // Grant outputs are registered from the next state so they line up with the FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         last_served <= 1'b1;
         xfer_cnt    <= '0;
         out_valid   <= 1'b0;
         gnt0        <= 1'b0;
         gnt1        <= 1'b0;
         sel         <= 1'b0;
      end else begin
         state     <= next_state;
         out_valid <= (next_state != IDLE);
         gnt0      <= (next_state == SERVE0);
         gnt1      <= (next_state == SERVE1);
         sel       <= (next_state == SERVE1);
         if (xfer) begin
            last_served <= (state == SERVE1);
            xfer_cnt    <= xfer_cnt + CNT_W'(1);
         end
      end
   end

   mux2ne1_w #(.WIDTH(WIDTH)) u_mux (
      .sel (sel),
      .d0  (data0),
      .d1  (data1),
      .y   (out_data)
   );

endmodule

// File: tb/tb_arbiter_2ne1.sv
// Directed self-checking bench for arbiter_2ne1 (4-bit transfer counter instance).
module tb_arbiter_2ne1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       req0 = 1'b0;
   logic       req1 = 1'b0;
   logic [7:0] data0 = '0;
   logic [7:0] data1 = '0;
   logic       out_ready = 1'b0;
   logic       out_valid;
   logic [7:0] out_data;
   logic       sel;
   logic       gnt0;
   logic       gnt1;
   logic [3:0] xfer_cnt;
`ifdef ARB_LOCK_EN
   logic       lock0 = 1'b0;
   logic       lock1 = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   arbiter_2ne1 #(.WIDTH(8), .CNT_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0      (req0),
      .req1      (req1),
      .data0     (data0),
      .data1     (data1),
`ifdef ARB_LOCK_EN
      .lock0     (lock0),
      .lock1     (lock1),
`endif
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .sel       (sel),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .xfer_cnt  (xfer_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, gnt1, gnt0, sel, xfer_cnt} !== 8'b0000_0000) begin
         errors++;
         $display("[TB] FAIL reset_state got %b want %b", {out_valid, gnt1, gnt0, sel, xfer_cnt}, 8'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      req0 = 1'b1; data0 = 8'hA5; out_ready = 1'b1;
      step();
      checks++;
      if ({out_valid, gnt1, gnt0, sel} !== 4'b1010 || out_data !== 8'hA5 || xfer_cnt !== 4'd0) begin
         errors++;
         $display("[TB] FAIL single_grant got v/g1/g0/sel=%b data=%h cnt=%0d want 1010 a5 0",
                  {out_valid, gnt1, gnt0, sel}, out_data, xfer_cnt);
      end
      req0 = 1'b0;
      step();
      checks++;
      if (xfer_cnt !== 4'd1 || out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_xfer got cnt=%0d valid=%b want 1 0", xfer_cnt, out_valid);
      end
   endtask

   task automatic test_contention();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if ({out_valid, gnt1, gnt0, sel} !== ((i % 2 == 0) ? 4'b1010 : 4'b1101) ||
             out_data !== ((i % 2 == 0) ? 8'h11 : 8'h22) || xfer_cnt !== 4'(i)) begin
            errors++;
            $display("[TB] FAIL contention_%0d got v/g1/g0/sel=%b data=%h cnt=%0d want sel=%0d cnt=%0d",
                     i, {out_valid, gnt1, gnt0, sel}, out_data, xfer_cnt, i % 2, i);
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      step();
      checks++;
      if (xfer_cnt !== 4'd4 || out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL contention_end got cnt=%0d valid=%b want 4 0", xfer_cnt, out_valid);
      end
   endtask

   task automatic test_backpressure();
      req1 = 1'b1; data1 = 8'h3C; out_ready = 1'b0;
      step();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({out_valid, gnt1, gnt0, sel} !== 4'b1101 || out_data !== 8'h3C || xfer_cnt !== 4'd4) begin
            errors++;
            $display("[TB] FAIL backpressure_%0d got v/g1/g0/sel=%b data=%h cnt=%0d want 1101 3c 4",
                     i, {out_valid, gnt1, gnt0, sel}, out_data, xfer_cnt);
         end
         step();
      end
      out_ready = 1'b1; req1 = 1'b0;
      step();
      checks++;
      if (xfer_cnt !== 4'd5 || out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL backpressure_release got cnt=%0d valid=%b want 5 0", xfer_cnt, out_valid);
      end
   endtask

   task automatic test_withdrawal();
      req1 = 1'b1; out_ready = 1'b0;
      step();
      req1 = 1'b0; req0 = 1'b1;
      step();
      checks++;
      if ({out_valid, gnt1, gnt0, sel} !== 4'b1010 || xfer_cnt !== 4'd5) begin
         errors++;
         $display("[TB] FAIL withdrawal got v/g1/g0/sel=%b cnt=%0d want 1010 5",
                  {out_valid, gnt1, gnt0, sel}, xfer_cnt);
      end
      req0 = 1'b0; out_ready = 1'b1;
      step();
      checks++;
      if (xfer_cnt !== 4'd6 || out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL withdrawal_xfer got cnt=%0d valid=%b want 6 0", xfer_cnt, out_valid);
      end
   endtask

   task automatic test_reset_mid_serve();
      req1 = 1'b1; out_ready = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, gnt1, gnt0, sel, xfer_cnt} !== 8'b0000_0000) begin
         errors++;
         $display("[TB] FAIL reset_mid_serve got %b want %b", {out_valid, gnt1, gnt0, sel, xfer_cnt}, 8'b0);
      end
      req1 = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_wrap();
      req0 = 1'b1; data0 = 8'h5A; out_ready = 1'b1;
      step();
      for (int i = 1; i <= 16; i++) begin
         step();
         checks++;
         if (xfer_cnt !== 4'(i) || out_valid !== 1'b1 || sel !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_%0d got cnt=%0d valid=%b sel=%b want %0d 1 0",
                     i, xfer_cnt, out_valid, sel, i % 16);
         end
      end
      req0 = 1'b0;
      step();
      checks++;
      if (xfer_cnt !== 4'd1 || out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wrap_end got cnt=%0d valid=%b want 1 0", xfer_cnt, out_valid);
      end
   endtask

`ifdef ARB_LOCK_EN
   task automatic test_lock();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      lock0 = 1'b1; req0 = 1'b1; req1 = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({gnt1, gnt0, sel} !== 3'b010 || xfer_cnt !== 4'(i)) begin
            errors++;
            $display("[TB] FAIL lock_%0d got g1/g0/sel=%b cnt=%0d want 010 %0d",
                     i, {gnt1, gnt0, sel}, xfer_cnt, i);
         end
      end
      lock0 = 1'b0;
      step();
      checks++;
      if ({gnt1, gnt0, sel} !== 3'b101 || xfer_cnt !== 4'd3) begin
         errors++;
         $display("[TB] FAIL lock_release got g1/g0/sel=%b cnt=%0d want 101 3", {gnt1, gnt0, sel}, xfer_cnt);
      end
      req0 = 1'b0; req1 = 1'b0;
      step();
   endtask
`endif

   initial begin
      #2;
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_withdrawal();
      test_reset_mid_serve();
      test_wrap();
`ifdef ARB_LOCK_EN
      test_lock();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/arbiter_2ne1.md
ARBITER_2NE1 -- requirements
Module: arbiter_2ne1

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of both requester data ports and the output.
REQ-002 SHALL have parameter CNT_W, default 8, width of the transfer counter.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have ports req0, req1  input  1 each  request from requester 0 / 1.
REQ-006 SHALL have ports data0, data1  input  WIDTH each  requester payloads; held stable while the matching req is high.
REQ-007 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-008 SHALL have port out_valid  output  1  out_data carries a granted payload.
REQ-009 SHALL have port out_data  output  WIDTH  selected payload.
REQ-010 SHALL have port sel  output  1  mux select; 0 selects data0, 1 selects data1.
REQ-011 SHALL have ports gnt0, gnt1  output  1 each  one-hot grant; at most one high.
REQ-012 SHALL have port xfer_cnt  output  CNT_W  count of completed transfers.

Function
REQ-013 SHALL implement FSM states IDLE, SERVE0 and SERVE1.
REQ-014 SHALL define a transfer as out_valid & out_ready high at a rising clk edge.
REQ-015 In IDLE with exactly one req high, SHALL enter that requester's SERVE state on the next edge.
REQ-016 In IDLE with both reqs high, SHALL grant the requester not recorded in last_served.
REQ-017 SHALL register sel, gnt0/gnt1 and out_valid, giving one cycle latency from req high to out_valid high.
REQ-018 SHALL drive out_data combinationally from data0/data1 via sel.
REQ-019 In SERVEi, SHALL hold out_valid=1, gnt_i=1 and sel=i stable until a transfer occurs.
REQ-020 On a transfer from SERVEi, SHALL set last_served=i and increment xfer_cnt, wrapping from 2^CNT_W-1 to 0.
REQ-021 After a transfer, SHALL re-arbitrate on the same edge using REQ-015/016 on the current reqs: the other requester is granted back-to-back with no idle cycle; the same requester is re-granted only if it alone requests; with no reqs the FSM returns to IDLE.
REQ-022 If req_i falls in SERVEi without a transfer, SHALL on the next edge drop the grant and re-arbitrate, leaving last_served and xfer_cnt unchanged.
REQ-023 SHALL guarantee no requester waits more than one transfer of the other while both request continuously.

Reset
REQ-024 While rst_n=0, SHALL immediately force the FSM to IDLE, out_valid=0, gnt0=gnt1=0, sel=0 and xfer_cnt=0, independent of clk.
REQ-025 SHALL reset last_served to 1, so requester 0 wins the first contested arbitration.
REQ-026 SHALL abandon an in-flight grant on reset and count nothing for it.

Configuration
REQ-027 With macro ARB_LOCK_EN defined, SHALL add inputs lock0 and lock1 (1 bit each); a transfer from SERVEi with lock_i=1 SHALL keep SERVEi while req_i stays high, regardless of the other req.
REQ-028 Without ARB_LOCK_EN, the lock ports SHALL be absent and arbitration SHALL be pure round-robin per REQ-021.

Structure
REQ-029 SHALL place FSM state encodings and the default WIDTH/CNT_W constants in shared package arb_pkg.
REQ-030 SHALL instantiate sub-module mux2ne1_w, a WIDTH-wide 2-to-1 mux, for out_data.

Verification
REQ-031 Reset: hold rst_n=0 mid-SERVE1 -> out_valid=0, gnt=00, sel=0 and xfer_cnt=0 within the same cycle.
REQ-032 Single request: req0=1, data0=8'hA5, out_ready=1 -> the next cycle shows out_valid=1, sel=0, out_data=8'hA5, and xfer_cnt increments by 1.
REQ-033 Contention: req0=req1=1 from reset, out_ready=1 -> grants alternate 0,1,0,1 back-to-back with no idle cycles.
REQ-034 Backpressure: out_ready=0 for 5 cycles in SERVE1 -> sel=1 and out_valid=1 hold; a single transfer occurs when out_ready rises.
REQ-035 Withdrawal: req1 falls in SERVE1 while out_ready=0 -> next cycle in IDLE or SERVE0, with xfer_cnt unchanged.
REQ-036 Wrap and lock: with CNT_W=4, 16 transfers -> xfer_cnt returns to 0; with ARB_LOCK_EN and lock0=1, requester 0 is served for 3 consecutive transfers despite req1=1.
